// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The master is the pipeline side; the slave is the unit itself.
interface muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, op, rs1, rs2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, op, rs1, rs2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide: radix-2 shift-add multiply and restoring
// divide on a shared 2*XLEN accumulator, one bit per cycle, sign-magnitude operands.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// CALC  | iterating, one bit per cycle, counter counts down to 1
// DONE  | result held until out_ready
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] most_neg = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc, acc_step;
    logic              neg_main, neg_rem;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              early;
    logic [XLEN-1:0]   early_res;
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

    assign accept        = bus.in_valid && (state == IDLE) && !bus.flush;
    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;

    // Operand signedness: MULH/DIV/REM treat both as signed, MULHSU only rs1.
    always_comb begin
        a_neg = bus.rs1[XLEN-1] && (bus.op == 3'd1 || bus.op == 3'd2 ||
                                    bus.op == 3'd4 || bus.op == 3'd6);
        b_neg = bus.rs2[XLEN-1] && (bus.op == 3'd1 || bus.op == 3'd4 || bus.op == 3'd6);
        a_mag = a_neg ? -bus.rs1 : bus.rs1;
        b_mag = b_neg ? -bus.rs2 : bus.rs2;
    end

    always_comb begin
        early     = 1'b0;
        early_res = '0;
        if (bus.op[2] && bus.rs2 == '0) begin
            early     = 1'b1;
            early_res = bus.op[1] ? bus.rs1 : '1;
        end else if (bus.op[2] && !bus.op[0] && bus.rs1 == most_neg && bus.rs2 == '1) begin
            early     = 1'b1;
            early_res = bus.op[1] ? '0 : bus.rs1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = early ? DONE : CALC;
            CALC:    if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    // Upper half: product high / partial remainder. Lower half: multiplier / quotient.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
        div_diff = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, b_q};
        if (!op_q[2])
            acc_step = {mul_sum, acc[XLEN-1:1]};
        else if (!div_diff[XLEN])
            acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_step = {acc[2*XLEN-2:0], 1'b0};
    end

    always_comb begin
        prod_fix = neg_main ? -acc_step : acc_step;
        quo_fix  = neg_main ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_fix  = neg_rem ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:             fin_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fin_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fin_res = quo_fix;
            default:          fin_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            b_q      <= '0;
            acc      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= bus.op;
            b_q      <= b_mag;
            acc      <= {{XLEN{1'b0}}, a_mag};
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            cnt      <= early ? '0 : CNT_W'(XLEN);
            if (early) result_q <= early_res;
        end else if (state == CALC && !bus.flush) begin
            acc <= acc_step;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) result_q <= fin_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32 and XLEN=16 against an arithmetic reference.
module tb_muldiv_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) b32 ();
    muldiv_if #(.XLEN(16)) b16 ();

    muldiv_unit #(.XLEN(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    muldiv_unit #(.XLEN(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    int          checks = 0;
    int          errors = 0;
    logic        pend32 = 1'b0;
    logic        pend16 = 1'b0;
    logic [31:0] exp32  = '0;
    logic [31:0] exp16  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference results from plain 64-bit arithmetic on xl-bit operands.
    function automatic logic [31:0] model(input int xl, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, p;
        longint      sa, sb, q, r, mn;
        mask = (64'd1 << xl) - 64'd1;
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        sa   = ua[xl-1] ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
        sb   = ub[xl-1] ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
        mn   = -(longint'(1) <<< (xl - 1));
        p    = '0;
        q    = 0;
        r    = 0;
        case (op)
            3'd0: p = ua * ub;
            3'd1: p = 64'(sa * sb);
            3'd2: p = 64'(sa * longint'(ub));
            3'd3: p = ua * ub;
            3'd4, 3'd6: begin
                if (sb == 0) begin q = -1; r = sa; end
                else if (sa == mn && sb == -1) begin q = sa; r = 0; end
                else begin q = sa / sb; r = sa % sb; end
            end
            default: begin
                if (ub == 0) begin q = -1; r = longint'(ua); end
                else begin q = longint'(ua / ub); r = longint'(ua % ub); end
            end
        endcase
        case (op)
            3'd0:             return 32'(p & mask);
            3'd1, 3'd2, 3'd3: return 32'((p >> xl) & mask);
            3'd4, 3'd5:       return 32'(64'(q) & mask);
            default:          return 32'(64'(r) & mask);
        endcase
    endfunction

    function automatic logic out_valid_of(input int w);
        return (w == 32) ? b32.out_valid : b16.out_valid;
    endfunction

    function automatic logic in_ready_of(input int w);
        return (w == 32) ? b32.in_ready : b16.in_ready;
    endfunction

    function automatic logic [31:0] result_of(input int w);
        return (w == 32) ? b32.result : {16'b0, b16.result};
    endfunction

    // Every cycle a result is presented, it must match the outstanding operation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b32.out_valid) begin
                if (pend32) chk("cmp32_result", {32'b0, b32.result}, {32'b0, exp32});
                else        chk("cmp32_unexpected_valid", {63'b0, b32.out_valid}, {63'b0, pend32});
            end
            if (b16.out_valid) begin
                if (pend16) chk("cmp16_result", {48'b0, b16.result}, {48'b0, exp16[15:0]});
                else        chk("cmp16_unexpected_valid", {63'b0, b16.out_valid}, {63'b0, pend16});
            end
        end
    end

    task automatic start(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = in_ready_of(w);
        end
        chk("in_ready_before_issue", {63'b0, got}, 64'd1);
        if (w == 32) begin
            b32.op = op; b32.rs1 = a; b32.rs2 = b; b32.in_valid = 1'b1;
            exp32 = model(32, op, a, b); pend32 = 1'b1;
        end else begin
            b16.op = op; b16.rs1 = a[15:0]; b16.rs2 = b[15:0]; b16.in_valid = 1'b1;
            exp16 = model(16, op, a, b); pend16 = 1'b1;
        end
        @(posedge clk);
        #1;
        // Operand changes after the accept edge must not matter.
        if (w == 32) begin
            b32.in_valid = 1'b0; b32.op = 3'($urandom); b32.rs1 = $urandom; b32.rs2 = $urandom;
        end else begin
            b16.in_valid = 1'b0; b16.op = 3'($urandom); b16.rs1 = 16'($urandom); b16.rs2 = 16'($urandom);
        end
    endtask

    task automatic finish(input int w, input logic [31:0] lit, input bit use_lit, input int exp_lat);
        int   lat, low;
        logic got;
        lat = 1;
        low = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (!in_ready_of(w)) low++;
            got = out_valid_of(w);
            if (!got) begin
                @(posedge clk);
                lat++;
            end
        end
        chk($sformatf("latency_w%0d", w), 64'(lat), 64'(exp_lat));
        chk($sformatf("in_ready_low_w%0d", w), 64'(low), 64'(exp_lat));
        if (use_lit) chk($sformatf("literal_w%0d", w), {32'b0, result_of(w)}, {32'b0, lit});
        if ((w == 32 && b32.out_ready) || (w == 16 && b16.out_ready)) begin
            @(posedge clk);
            #1;
            if (w == 32) pend32 = 1'b0; else pend16 = 1'b0;
        end
    endtask

    task automatic issue(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input bit use_lit, input int exp_lat);
        start(w, op, a, b);
        finish(w, lit, use_lit, exp_lat);
    endtask

    initial begin
        b32.flush = 0; b32.in_valid = 0; b32.op = 0; b32.rs1 = 0; b32.rs2 = 0; b32.out_ready = 1;
        b16.flush = 0; b16.in_valid = 0; b16.op = 0; b16.rs1 = 0; b16.rs2 = 0; b16.out_ready = 1;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {63'b0, b32.out_valid}, 64'd0);
        chk("reset_result", {32'b0, b32.result}, 64'd0);
        chk("reset_busy", {63'b0, b32.busy}, 64'd0);
        chk("reset_result16", {48'b0, b16.result}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {63'b0, b32.in_ready}, 64'd1);

        issue(32, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 33);
        issue(32, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 33);
        issue(32, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 33);
        issue(32, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 33);
        issue(32, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, 33);
        issue(32, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, 33);
        issue(32, 3'd5, 32'd100, 32'd7, 32'd14, 1, 33);
        issue(32, 3'd7, 32'd100, 32'd7, 32'd2, 1, 33);
        issue(32, 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 1);
        issue(32, 3'd6, 32'd100, 32'd0, 32'd100, 1, 1);
        issue(32, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        issue(32, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1);
        issue(32, 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 1, 33);
        issue(32, 3'd4, 32'h8000_0000, 32'd1, 32'h8000_0000, 1, 33);

        for (int i = 0; i < 6; i++) begin
            logic [2:0] rop;
            rop = (i % 3 == 0) ? 3'd0 : (i % 3 == 1) ? 3'd1 : 3'd5;
            issue(32, rop, $urandom, $urandom | 32'd1, 32'd0, 0, 33);
        end

        // Backpressure: result held while out_ready is low.
        b32.out_ready = 1'b0;
        issue(32, 3'd5, 32'd100, 32'd7, 32'd14, 1, 33);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {63'b0, b32.out_valid}, 64'd1);
            chk("bp_result", {32'b0, b32.result}, 64'd14);
            chk("bp_in_ready", {63'b0, b32.in_ready}, 64'd0);
        end
        b32.out_ready = 1'b1;
        @(posedge clk); #1 pend32 = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", {63'b0, b32.in_ready}, 64'd1);

        // Flush mid-CALC: no result may appear.
        start(32, 3'd0, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #1 b32.flush = 1'b1;
        @(posedge clk); #1 b32.flush = 1'b0; pend32 = 1'b0;
        @(negedge clk);
        chk("flush_busy", {63'b0, b32.busy}, 64'd0);
        repeat (40) @(negedge clk);

        // A request coinciding with flush is not accepted.
        b32.op = 3'd5; b32.rs1 = 32'd9; b32.rs2 = 32'd3; b32.in_valid = 1'b1; b32.flush = 1'b1;
        @(posedge clk); #1 b32.in_valid = 1'b0; b32.flush = 1'b0;
        @(negedge clk);
        chk("flush_blocks_accept", {63'b0, b32.busy}, 64'd0);
        issue(32, 3'd5, 32'd9, 32'd3, 32'd3, 1, 33);

        // Reset mid-operation.
        start(32, 3'd5, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0; pend32 = 1'b0;
        #1;
        chk("rst_mid_out_valid", {63'b0, b32.out_valid}, 64'd0);
        chk("rst_mid_result", {32'b0, b32.result}, 64'd0);
        chk("rst_mid_busy", {63'b0, b32.busy}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", {63'b0, b32.in_ready}, 64'd1);
        issue(32, 3'd5, 32'd1000, 32'd7, 32'd142, 1, 33);

        issue(16, 3'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0001, 1, 17);
        issue(16, 3'd1, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1, 17);
        issue(16, 3'd5, 32'd1000, 32'd7, 32'd142, 1, 17);
        issue(16, 3'd4, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_8000, 1, 1);
        issue(16, 3'd6, 32'h0000_FFF9, 32'd2, 32'h0000_FFFF, 1, 17);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
